// File: rtl/algo_ctrl_pkg.sv
// Shared types and constants for the ALGO frame controller and its configuration shadow.
// The threshold defaults are also used by the hue stage.
package algo_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmed  = 2'd1,
    StActive = 2'd2,
    StSkip   = 2'd3
  } ctrl_state_e;

  localparam int unsigned NUM_THR = 6;

  localparam logic [2:0] CFG_SEL_H_MIN = 3'd0;
  localparam logic [2:0] CFG_SEL_H_MAX = 3'd1;
  localparam logic [2:0] CFG_SEL_S_MIN = 3'd2;
  localparam logic [2:0] CFG_SEL_S_MAX = 3'd3;
  localparam logic [2:0] CFG_SEL_V_MIN = 3'd4;
  localparam logic [2:0] CFG_SEL_V_MAX = 3'd5;

  // IEEE-754 single: 0.0 and 0.1
  localparam logic [31:0] H_MIN_DEF = 32'h0000_0000;
  localparam logic [31:0] H_MAX_DEF = 32'h3DCC_CCCD;
  localparam logic [31:0] S_MIN_DEF = 32'h0000_0000;
  localparam logic [31:0] S_MAX_DEF = 32'h3DCC_CCCD;
  localparam logic [31:0] V_MIN_DEF = 32'h0000_0000;
  localparam logic [31:0] V_MAX_DEF = 32'h3DCC_CCCD;

  function automatic logic cfg_sel_valid(input logic [2:0] sel);
    return sel <= CFG_SEL_V_MAX;
  endfunction

endpackage

// File: rtl/algo_cfg_shadow.sv
// Six shadow/active threshold register pairs with a pending flag.
// Active copies update only on commit, so a frame never sees a mix of old and new values.
module algo_cfg_shadow
  import algo_ctrl_pkg::*;
#(
  parameter logic [31:0] H_MIN_RST = H_MIN_DEF,
  parameter logic [31:0] H_MAX_RST = H_MAX_DEF,
  parameter logic [31:0] S_MIN_RST = S_MIN_DEF,
  parameter logic [31:0] S_MAX_RST = S_MAX_DEF,
  parameter logic [31:0] V_MIN_RST = V_MIN_DEF,
  parameter logic [31:0] V_MAX_RST = V_MAX_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [2:0]  wr_sel_i,
  input  logic [31:0] wr_data_i,
  input  logic        commit_i,
  input  logic        idle_i,
  output logic [31:0] h_min_o,
  output logic [31:0] h_max_o,
  output logic [31:0] s_min_o,
  output logic [31:0] s_max_o,
  output logic [31:0] v_min_o,
  output logic [31:0] v_max_o,
  output logic        pending_o
);

  localparam logic [NUM_THR-1:0][31:0] RstVal =
    {V_MAX_RST, V_MIN_RST, S_MAX_RST, S_MIN_RST, H_MAX_RST, H_MIN_RST};

  logic [NUM_THR-1:0][31:0] shadow_q, shadow_d;
  logic [NUM_THR-1:0][31:0] active_q, active_d;
  logic                     pending_q, pending_d;
  logic                     wr_idle_q;
  logic                     wr_hit;
  logic                     commit;

  always_comb begin
    wr_hit    = wr_en_i && cfg_sel_valid(wr_sel_i);
    // Writes made while idle commit on the following cycle.
    commit    = commit_i || wr_idle_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (commit) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (wr_hit) begin
      shadow_d[wr_sel_i] = wr_data_i;
      pending_d          = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q  <= RstVal;
      active_q  <= RstVal;
      pending_q <= 1'b0;
      wr_idle_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      wr_idle_q <= wr_en_i && idle_i;
    end
  end

  assign h_min_o   = active_q[CFG_SEL_H_MIN];
  assign h_max_o   = active_q[CFG_SEL_H_MAX];
  assign s_min_o   = active_q[CFG_SEL_S_MIN];
  assign s_max_o   = active_q[CFG_SEL_S_MAX];
  assign v_min_o   = active_q[CFG_SEL_V_MIN];
  assign v_max_o   = active_q[CFG_SEL_V_MAX];
  assign pending_o = pending_q;

endmodule

// File: rtl/algo_frame_ctrl.sv
// Frame sequencer for the ALGO colour pipeline: gates camera sync/enable on frame
// boundaries, decimates frames, owns threshold configuration and status counters.
module algo_frame_ctrl
  import algo_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_SKIP = 0,
  parameter int unsigned PIX_W      = 12,
  parameter int unsigned LINE_W     = 11,
  parameter logic [31:0] H_MIN_RST  = H_MIN_DEF,
  parameter logic [31:0] H_MAX_RST  = H_MAX_DEF,
  parameter logic [31:0] S_MIN_RST  = S_MIN_DEF,
  parameter logic [31:0] S_MAX_RST  = S_MAX_DEF,
  parameter logic [31:0] V_MIN_RST  = V_MIN_DEF,
  parameter logic [31:0] V_MAX_RST  = V_MAX_DEF
) (
  input  logic              i_cmos_d_pclk,
  input  logic              i_cmos_rst,
  input  logic              i_enable,
  input  logic              i_cmos_vsys,
  input  logic              i_cmos_href,
  input  logic              i_cmos_de,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [2:0]        i_cfg_sel,
  input  logic [31:0]       i_cfg_data,
  output logic              o_vsys,
  output logic              o_href,
  output logic              o_de,
  output logic [31:0]       o_h_min,
  output logic [31:0]       o_h_max,
  output logic [31:0]       o_s_min,
  output logic [31:0]       o_s_max,
  output logic [31:0]       o_v_min,
  output logic [31:0]       o_v_max,
  output logic              o_cfg_pending,
  output logic [15:0]       o_frame_cnt,
  output logic [LINE_W-1:0] o_line_cnt,
  output logic [PIX_W-1:0]  o_pix_cnt,
  output logic [1:0]        o_state
);

  localparam int unsigned SkipW = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;
  localparam logic [SkipW-1:0] SkipReload = SkipW'(FRAME_SKIP);

  ctrl_state_e       state_q, state_d;
  logic [SkipW-1:0]  skip_q, skip_d;
  logic              vs_q, href_q;
  logic              fs, href_fall, pass, cfg_accept;
  logic              vsys_q, href_g_q, de_q;
  logic [15:0]       frame_q, frame_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [PIX_W-1:0]  pix_q, pix_d;

  assign fs        = i_cmos_vsys && !vs_q;
  assign href_fall = !i_cmos_href && href_q;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    case (state_q)
      StIdle: begin
        if (i_enable) state_d = StArmed;
      end
      StArmed: begin
        if (!i_enable) begin
          state_d = StIdle;
        end else if (fs) begin
          state_d = StActive;
          skip_d  = SkipReload;
        end
      end
      StActive, StSkip: begin
        // Disable only lands on a frame boundary so the running frame completes.
        if (fs) begin
          if (!i_enable) begin
            state_d = StIdle;
          end else if (skip_q == '0) begin
            state_d = StActive;
            skip_d  = SkipReload;
          end else begin
            state_d = StSkip;
            skip_d  = skip_q - SkipW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Gating looks at the next state so the frame-start cycle itself is passed.
  assign pass        = (state_d == StActive);
  assign o_cfg_ready = !(fs && (state_q != StIdle));
  assign cfg_accept  = i_cfg_valid && o_cfg_ready;

  always_comb begin
    pix_d   = pix_q;
    line_d  = line_q;
    frame_d = frame_q;
    if (fs) begin
      pix_d  = '0;
      line_d = '0;
    end else begin
      if (href_fall) begin
        pix_d = '0;
      end else if (i_cmos_de && pass) begin
        pix_d = pix_q + PIX_W'(1);
      end
      if (href_fall && (state_q == StActive)) line_d = line_q + LINE_W'(1);
    end
    if (fs && pass) frame_d = frame_q + 16'd1;
  end

  always_ff @(posedge i_cmos_d_pclk or posedge i_cmos_rst) begin
    if (i_cmos_rst) begin
      state_q  <= StIdle;
      skip_q   <= '0;
      vs_q     <= 1'b0;
      href_q   <= 1'b0;
      vsys_q   <= 1'b0;
      href_g_q <= 1'b0;
      de_q     <= 1'b0;
      frame_q  <= '0;
      line_q   <= '0;
      pix_q    <= '0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      vs_q     <= i_cmos_vsys;
      href_q   <= i_cmos_href;
      vsys_q   <= i_cmos_vsys && pass;
      href_g_q <= i_cmos_href && pass;
      de_q     <= i_cmos_de && pass;
      frame_q  <= frame_d;
      line_q   <= line_d;
      pix_q    <= pix_d;
    end
  end

  algo_cfg_shadow #(
    .H_MIN_RST (H_MIN_RST),
    .H_MAX_RST (H_MAX_RST),
    .S_MIN_RST (S_MIN_RST),
    .S_MAX_RST (S_MAX_RST),
    .V_MIN_RST (V_MIN_RST),
    .V_MAX_RST (V_MAX_RST)
  ) u_cfg_shadow (
    .clk_i     (i_cmos_d_pclk),
    .rst_i     (i_cmos_rst),
    .wr_en_i   (cfg_accept),
    .wr_sel_i  (i_cfg_sel),
    .wr_data_i (i_cfg_data),
    .commit_i  (fs && (state_q != StIdle)),
    .idle_i    (state_q == StIdle),
    .h_min_o   (o_h_min),
    .h_max_o   (o_h_max),
    .s_min_o   (o_s_min),
    .s_max_o   (o_s_max),
    .v_min_o   (o_v_min),
    .v_max_o   (o_v_max),
    .pending_o (o_cfg_pending)
  );

  assign o_vsys      = vsys_q;
  assign o_href      = href_g_q;
  assign o_de        = de_q;
  assign o_frame_cnt = frame_q;
  assign o_line_cnt  = line_q;
  assign o_pix_cnt   = pix_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_algo_frame_ctrl.sv
// Bench for algo_frame_ctrl: two instances (no decimation, and FRAME_SKIP=2) share stimulus
// and are checked each cycle against a frame-level model plus literal spot checks.
module tb_algo_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, vsys = 1'b0, href = 1'b0, de = 1'b0, cfg_valid = 1'b0;
  logic [2:0]  cfg_sel = 3'd0;
  logic [31:0] cfg_data = 32'd0;
  bit          started = 1'b0;
  int          total = 0, bad = 0;

  logic        dut_ready [2], dut_vsys [2], dut_href [2], dut_de [2], dut_pend [2];
  logic [31:0] dut_thr [2][6];
  logic [15:0] dut_frame [2];
  logic [10:0] dut_line [2];
  logic [11:0] dut_pix [2];
  logic [1:0]  dut_state [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    algo_frame_ctrl #(.FRAME_SKIP((g == 0) ? 0 : 2)) u_dut (
      .i_cmos_d_pclk (clk),
      .i_cmos_rst    (rst),
      .i_enable      (en),
      .i_cmos_vsys   (vsys),
      .i_cmos_href   (href),
      .i_cmos_de     (de),
      .i_cfg_valid   (cfg_valid),
      .o_cfg_ready   (dut_ready[g]),
      .i_cfg_sel     (cfg_sel),
      .i_cfg_data    (cfg_data),
      .o_vsys        (dut_vsys[g]),
      .o_href        (dut_href[g]),
      .o_de          (dut_de[g]),
      .o_h_min       (dut_thr[g][0]),
      .o_h_max       (dut_thr[g][1]),
      .o_s_min       (dut_thr[g][2]),
      .o_s_max       (dut_thr[g][3]),
      .o_v_min       (dut_thr[g][4]),
      .o_v_max       (dut_thr[g][5]),
      .o_cfg_pending (dut_pend[g]),
      .o_frame_cnt   (dut_frame[g]),
      .o_line_cnt    (dut_line[g]),
      .o_pix_cnt     (dut_pix[g]),
      .o_state       (dut_state[g])
    );
  end

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 armed, 2 running; a running frame passes when its index since
  // arming is a multiple of (skip+1).
  int          m_mode [2], m_k [2];
  bit          m_runpass [2], m_vs_p [2], m_hr_p [2], m_idle_wr [2], m_pend [2];
  bit          e_vs [2], e_hr [2], e_de [2];
  int          e_frame [2], e_line [2], e_pix [2];
  logic [31:0] m_shadow [2][6], m_active [2][6];

  function automatic int skip_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic logic [31:0] thr_def(input int i);
    return (i % 2 == 1) ? 32'h3DCC_CCCD : 32'h0000_0000;
  endfunction

  function automatic int exp_state(input int d);
    if (m_mode[d] == 2) return m_runpass[d] ? 2 : 3;
    return m_mode[d];
  endfunction

  task automatic model_reset(input int d);
    m_mode[d] = 0; m_k[d] = 0; m_runpass[d] = 0; m_vs_p[d] = 0; m_hr_p[d] = 0;
    m_idle_wr[d] = 0; m_pend[d] = 0; e_vs[d] = 0; e_hr[d] = 0; e_de[d] = 0;
    e_frame[d] = 0; e_line[d] = 0; e_pix[d] = 0;
    for (int i = 0; i < 6; i++) begin
      m_shadow[d][i] = thr_def(i);
      m_active[d][i] = thr_def(i);
    end
  endtask

  task automatic model_step(input int d);
    bit fs, acc, commit, line_active, pass, hfall;
    int old_mode;
    fs          = vsys && !m_vs_p[d];
    hfall       = !href && m_hr_p[d];
    acc         = cfg_valid && !(fs && m_mode[d] != 0);
    commit      = (fs && m_mode[d] != 0) || m_idle_wr[d];
    line_active = (m_mode[d] == 2) && m_runpass[d];
    old_mode    = m_mode[d];
    if (m_mode[d] == 0) begin
      if (en) m_mode[d] = 1;
    end else if (m_mode[d] == 1) begin
      if (!en) m_mode[d] = 0;
      else if (fs) begin m_mode[d] = 2; m_k[d] = 0; m_runpass[d] = 1; end
    end else if (fs) begin
      if (!en) m_mode[d] = 0;
      else begin
        m_k[d]++;
        m_runpass[d] = (m_k[d] % (skip_of(d) + 1)) == 0;
      end
    end
    pass     = (m_mode[d] == 2) && m_runpass[d];
    e_vs[d]  = vsys && pass;
    e_hr[d]  = href && pass;
    e_de[d]  = de && pass;
    if (fs || hfall) e_pix[d] = 0;
    else if (de && pass) e_pix[d] = (e_pix[d] + 1) % 4096;
    if (fs) e_line[d] = 0;
    else if (hfall && line_active) e_line[d] = (e_line[d] + 1) % 2048;
    if (fs && pass) e_frame[d] = (e_frame[d] + 1) % 65536;
    if (commit) for (int i = 0; i < 6; i++) m_active[d][i] = m_shadow[d][i];
    if (acc && cfg_sel < 3'd6) begin
      m_shadow[d][cfg_sel] = cfg_data;
      m_pend[d] = 1;
    end else if (commit) begin
      m_pend[d] = 0;
    end
    m_idle_wr[d] = acc && (old_mode == 0);
    m_vs_p[d]    = vsys;
    m_hr_p[d]    = href;
  endtask

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) model_reset(d);
      else model_step(d);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("ready%0d", d), 32'(dut_ready[d]),
            32'(!(vsys && !m_vs_p[d] && m_mode[d] != 0)));
        chk($sformatf("vsys%0d", d), 32'(dut_vsys[d]), 32'(e_vs[d]));
        chk($sformatf("href%0d", d), 32'(dut_href[d]), 32'(e_hr[d]));
        chk($sformatf("de%0d", d), 32'(dut_de[d]), 32'(e_de[d]));
        chk($sformatf("state%0d", d), 32'(dut_state[d]), exp_state(d));
        chk($sformatf("frame%0d", d), 32'(dut_frame[d]), e_frame[d]);
        chk($sformatf("line%0d", d), 32'(dut_line[d]), e_line[d]);
        chk($sformatf("pix%0d", d), 32'(dut_pix[d]), e_pix[d]);
        chk($sformatf("pending%0d", d), 32'(dut_pend[d]), 32'(m_pend[d]));
        for (int i = 0; i < 6; i++)
          chk($sformatf("thr%0d_%0d", d, i), dut_thr[d][i], m_active[d][i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Frame of 4 lines x 8 pixels; optional disable at a line, mid-frame H_MAX write,
  // or an S_MIN write held across the frame-start cycle.
  task automatic frame(input int dis_line, input bit wr_mid, input bit wr_fs);
    cyc();
    vsys = 1'b1;
    if (wr_fs) begin
      cfg_valid = 1'b1; cfg_sel = 3'd2; cfg_data = 32'h3F00_0000;
      @(negedge clk);
      chk("ready_low_at_fs", 32'(dut_ready[0]), 32'd0);
    end
    cyc();
    if (wr_fs) begin
      @(negedge clk);
      chk("h_max_after_fs", dut_thr[0][1], 32'h3E4C_CCCD);
      chk("pending_after_fs", 32'(dut_pend[0]), 32'd0);
    end
    cyc();
    vsys = 1'b0; cfg_valid = 1'b0;
    cyc();
    for (int l = 0; l < 4; l++) begin
      if (l == dis_line) en = 1'b0;
      for (int p = 0; p < 8; p++) begin
        cyc();
        href = 1'b1; de = 1'b1;
        if (wr_mid && l == 1 && p == 0) begin
          cfg_valid = 1'b1; cfg_sel = 3'd1; cfg_data = 32'h3E4C_CCCD;
        end else begin
          cfg_valid = 1'b0;
        end
      end
      cyc();
      href = 1'b0; de = 1'b0;
      cyc();
    end
    cyc();
    cyc();
  endtask

  initial begin
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    started = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(dut_state[0]), 32'd0);
    chk("rst_h_max", dut_thr[0][1], 32'h3DCC_CCCD);
    chk("rst_ready", 32'(dut_ready[0]), 32'd1);

    en = 1'b1;
    cyc();
    @(negedge clk);
    chk("armed", 32'(dut_state[0]), 32'd1);

    frame(-1, 1'b0, 1'b0);
    chk("f1_state0", 32'(dut_state[0]), 32'd2);
    chk("f1_state1", 32'(dut_state[1]), 32'd2);
    frame(-1, 1'b0, 1'b0);
    chk("f2_skip1", 32'(dut_state[1]), 32'd3);
    frame(-1, 1'b0, 1'b0);
    chk("f3_frames0", 32'(dut_frame[0]), 32'd3);
    chk("f3_lines0", 32'(dut_line[0]), 32'd4);
    chk("f3_frames1", 32'(dut_frame[1]), 32'd1);

    frame(-1, 1'b1, 1'b0);
    chk("f4_state1", 32'(dut_state[1]), 32'd2);
    chk("f4_h_max_held", dut_thr[0][1], 32'h3DCC_CCCD);
    chk("f4_pending", 32'(dut_pend[0]), 32'd1);
    frame(-1, 1'b0, 1'b1);
    chk("f5_pending", 32'(dut_pend[0]), 32'd1);
    chk("f5_s_min_held", dut_thr[0][2], 32'h0000_0000);
    frame(-1, 1'b0, 1'b0);
    chk("f6_s_min", dut_thr[0][2], 32'h3F00_0000);
    chk("f6_frames0", 32'(dut_frame[0]), 32'd6);
    chk("f6_frames1", 32'(dut_frame[1]), 32'd2);

    frame(2, 1'b0, 1'b0);
    chk("f7_still_active", 32'(dut_state[0]), 32'd2);
    chk("f7_lines0", 32'(dut_line[0]), 32'd4);
    frame(-1, 1'b0, 1'b0);
    chk("f8_idle0", 32'(dut_state[0]), 32'd0);
    chk("f8_idle1", 32'(dut_state[1]), 32'd0);
    chk("f8_frames0", 32'(dut_frame[0]), 32'd7);
    chk("f8_frames1", 32'(dut_frame[1]), 32'd3);

    // Idle writes commit one cycle after acceptance.
    cyc();
    cfg_valid = 1'b1; cfg_sel = 3'd5; cfg_data = 32'h3F80_0000;
    cyc();
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("idle_pending", 32'(dut_pend[0]), 32'd1);
    chk("idle_v_max_old", dut_thr[0][5], 32'h3DCC_CCCD);
    cyc();
    @(negedge clk);
    chk("idle_v_max_new", dut_thr[0][5], 32'h3F80_0000);
    chk("idle_pending_clr", 32'(dut_pend[0]), 32'd0);
    cyc();
    cfg_valid = 1'b1; cfg_sel = 3'd6; cfg_data = 32'hFFFF_FFFF;
    cyc();
    cfg_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("reserved_pending", 32'(dut_pend[0]), 32'd0);
    chk("reserved_v_max", dut_thr[0][5], 32'h3F80_0000);

    // Asynchronous reset in the middle of a passed line.
    en = 1'b1;
    cyc();
    cyc();
    vsys = 1'b1;
    cyc();
    cyc();
    vsys = 1'b0;
    cyc();
    href = 1'b1; de = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk("pre_rst_de", 32'(dut_de[0]), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_de", 32'(dut_de[0]), 32'd0);
    chk("arst_href", 32'(dut_href[0]), 32'd0);
    chk("arst_vsys", 32'(dut_vsys[0]), 32'd0);
    chk("arst_h_max", dut_thr[0][1], 32'h3DCC_CCCD);
    chk("arst_v_max", dut_thr[0][5], 32'h3DCC_CCCD);
    chk("arst_frames", 32'(dut_frame[0]), 32'd0);
    chk("arst_state", 32'(dut_state[0]), 32'd0);
    cyc();
    href = 1'b0; de = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    frame(-1, 1'b0, 1'b0);
    chk("post_rst_frames0", 32'(dut_frame[0]), 32'd1);
    chk("post_rst_frames1", 32'(dut_frame[1]), 32'd1);
    chk("post_rst_lines0", 32'(dut_line[0]), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
